// File: rtl/proc_control.sv
// proc_control: four-step control FSM for a simple bus-based processor.
// Decodes state, IR and Gnz into one-hot register selects and bus/ALU/memory strobes.
module proc_control (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] IR,
    input  logic       Gnz,
    output logic       IRin,
    output logic [7:0] Rout,
    output logic [7:0] Rin,
    output logic       Gout,
    output logic       DINout,
    output logic       Memout,
    output logic       Ain,
    output logic       Gin,
    output logic       AddSub,
    output logic       ADDRin,
    output logic       DOUTin,
    output logic       W_D,
    output logic       Done,
    output logic [1:0] Tstep
);
    typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
    localparam logic [2:0] MV = 3'b000, MVI = 3'b001, ADD = 3'b010, SUB = 3'b011;
    localparam logic [2:0] LD = 3'b100, ST = 3'b101, MVNZ = 3'b110, RSV = 3'b111;
    state_t state, next;
    logic [2:0] op;
    logic [7:0] x_sel, y_sel;
    assign op    = IR[8:6];
    assign x_sel = 8'h80 >> IR[5:3];
    assign y_sel = 8'h80 >> IR[2:0];
    assign Tstep = state;
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) state <= T0;
        else         state <= next;
    always_comb begin
        IRin   = 1'b0;
        Rout   = '0;
        Rin    = '0;
        Gout   = 1'b0;
        DINout = 1'b0;
        Memout = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AddSub = 1'b0;
        ADDRin = 1'b0;
        DOUTin = 1'b0;
        W_D    = 1'b0;
        Done   = 1'b0;
        unique case (state)
            // Run is gated by Resetn so IRin stays low while reset is held
            T0: IRin = Resetn & Run;
            T1: case (op)
                MV:       begin Rout = y_sel; Rin = x_sel; Done = 1'b1; end
                MVI:      begin DINout = 1'b1; Rin = x_sel; Done = 1'b1; end
                ADD, SUB: begin Rout = x_sel; Ain = 1'b1; end
                LD, ST:   begin Rout = y_sel; ADDRin = 1'b1; end
                MVNZ:     begin Rout = y_sel; Rin = Gnz ? x_sel : '0; Done = 1'b1; end
                RSV:      Done = 1'b1;
            endcase
            T2: case (op)
                ADD, SUB: begin Rout = y_sel; Gin = 1'b1; AddSub = (op == SUB); end
                ST:       begin Rout = x_sel; DOUTin = 1'b1; end
                default:  ;
            endcase
            T3: case (op)
                ADD, SUB: begin Gout = 1'b1; Rin = x_sel; Done = 1'b1; end
                LD:       begin Memout = 1'b1; Rin = x_sel; Done = 1'b1; end
                ST:       begin W_D = 1'b1; Done = 1'b1; end
                default:  Done = 1'b1;
            endcase
        endcase
        next = (state == T0) ? (Run ? T1 : T0) : Done ? T0 : state_t'(state + 2'd1);
    end
endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: randomized instruction stream checked against a micro-step schedule model.
module tb_proc_control;
    logic       Clock = 1'b0, Resetn = 1'b0, Run = 1'b0, Gnz = 1'b0;
    logic [8:0] IR = '0;
    logic       IRin, Gout, DINout, Memout, Ain, Gin, AddSub, ADDRin, DOUTin, W_D, Done;
    logic [7:0] Rout, Rin;
    logic [1:0] Tstep;
    int errors = 0, checks = 0;

    typedef struct packed {
        logic       irin;
        logic [7:0] rout, rin;
        logic       gout, dinout, memout, ain, gin, addsub, addrin, doutin, wd, done;
        logic [1:0] tstep;
    } exp_t;
    exp_t exp_q[$];

    proc_control dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR), .Gnz(Gnz),
        .IRin(IRin), .Rout(Rout), .Rin(Rin), .Gout(Gout), .DINout(DINout), .Memout(Memout),
        .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .ADDRin(ADDRin), .DOUTin(DOUTin),
        .W_D(W_D), .Done(Done), .Tstep(Tstep)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    function automatic exp_t observed();
        return exp_t'({IRin, Rout, Rin, Gout, DINout, Memout, Ain, Gin, AddSub,
                       ADDRin, DOUTin, W_D, Done, Tstep});
    endfunction

    function automatic logic [7:0] reg_sel(input logic [2:0] n);
        logic [7:0] v = '0;
        v[3'd7 - n] = 1'b1;
        return v;
    endfunction

    // Builds the expected per-cycle outputs of one instruction, T0 fetch first.
    function automatic void plan(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y, input logic g);
        exp_t e [4];
        int n;
        e = '{default: '0};
        e[0].irin = 1'b1;
        case (op)
            3'd0: begin n = 2; e[1].rout = reg_sel(y); e[1].rin = reg_sel(x); e[1].done = 1; end
            3'd1: begin n = 2; e[1].dinout = 1; e[1].rin = reg_sel(x); e[1].done = 1; end
            3'd6: begin n = 2; e[1].rout = reg_sel(y); e[1].rin = g ? reg_sel(x) : 8'h00; e[1].done = 1; end
            3'd7: begin n = 2; e[1].done = 1; end
            3'd2, 3'd3: begin
                n = 4;
                e[1].rout = reg_sel(x); e[1].ain = 1;
                e[2].rout = reg_sel(y); e[2].gin = 1; e[2].addsub = (op == 3'd3);
                e[3].gout = 1; e[3].rin = reg_sel(x); e[3].done = 1;
            end
            3'd4: begin
                n = 4;
                e[1].rout = reg_sel(y); e[1].addrin = 1;
                e[3].memout = 1; e[3].rin = reg_sel(x); e[3].done = 1;
            end
            default: begin
                n = 4;
                e[1].rout = reg_sel(y); e[1].addrin = 1;
                e[2].rout = reg_sel(x); e[2].doutin = 1;
                e[3].wd = 1; e[3].done = 1;
            end
        endcase
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            e[i].tstep = 2'(i);
            exp_q.push_back(e[i]);
        end
    endfunction

    task automatic cycle(input exp_t e, input string tag, input logic run, input logic [8:0] ir, input logic g);
        @(negedge Clock);
        Run = run; IR = ir; Gnz = g;
        #1;
        chk(tag, 32'(observed()), 32'(e));
        chk("bus_excl", 32'(((Rout != 0) + Gout + DINout + Memout) <= 1), 32'd1);
        chk("onehot", 32'($countones(Rout) <= 1 && $countones(Rin) <= 1), 32'd1);
    endtask

    task automatic exec(input logic [8:0] ir, input logic g);
        plan(ir[8:6], ir[5:3], ir[2:0], g);
        foreach (exp_q[i])
            cycle(exp_q[i], $sformatf("ir%03h_s%0d", ir, i), (i == 0) ? 1'b1 : 1'($urandom), ir, g);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle('0, "idle", 1'b0, 9'($urandom), 1'($urandom));
    endtask

    initial begin
        Run = 1'b1;
        #12;
        chk("reset_hold", 32'(observed()), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1; Run = 1'b0;
        idle(2);
        exec(9'b001_010_000, 1'b0);
        exec(9'b010_001_011, 1'b1);
        exec(9'b011_110_110, 1'b0);
        exec(9'b110_111_000, 1'b0);
        exec(9'b110_111_000, 1'b1);
        exec(9'b101_100_101, 1'b0);
        exec(9'b100_011_011, 1'b1);
        exec(9'b000_000_111, 1'b0);
        exec(9'b111_101_010, 1'b1);
        idle(1);
        // asynchronous reset in the middle of a load's latency cycle
        plan(3'd4, 3'd0, 3'd1, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(exp_q[i], $sformatf("ld_pre_s%0d", i), (i == 0) ? 1'b1 : 1'b0, 9'b100_000_001, 1'b0);
        #2;
        Resetn = 1'b0; Run = 1'b1;
        #1;
        chk("reset_mid", 32'(observed()), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1; Run = 1'b0;
        #1;
        chk("reset_release", 32'(observed()), 32'd0);
        idle(3);
        repeat (300) begin
            exec(9'($urandom), 1'($urandom));
            idle(int'($urandom_range(0, 2)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
